// File: rtl/line_buf_pkg.sv
// Shared definitions for the line buffer controller: FSM encoding, address
// width and the modulo pointer step.
package line_buf_pkg;

  localparam int unsigned ADDR_W = 8;
  // One bit wider than ADDR_W so that a completely full 256-row buffer is representable
  localparam int unsigned FILL_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } lb_state_e;

  // Advance a row pointer, wrapping from last back to 0
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] ptr,
                                                 input logic [ADDR_W-1:0] last);
    return (ptr == last) ? '0 : ADDR_W'(ptr + 1'b1);
  endfunction

endpackage

// File: rtl/line_buf_ptr.sv
// Modulo-DEPTH row pointer with increment enable.
module line_buf_ptr
  import line_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Next pointer value
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = wrap_inc(ptr_q, LAST);
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/line_buf_ctrl.sv
// Line buffer controller: packs an upstream word stream into rows of a shift
// RAM and hands complete rows to a consumer. Optional partial-row flush is
// compiled in with LINE_BUF_CTRL_FLUSH_EN.
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LENGTH     = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef LINE_BUF_CTRL_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_W-1:0]     ram_wr_addr,
  output logic [ADDR_W-1:0]     ram_rd_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     rows_full
);

  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(LENGTH - 1);
  localparam logic [FILL_W-1:0] DEPTH_C   = FILL_W'(DEPTH);

  lb_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     word_cnt_q, word_cnt_d;
  logic [FILL_W-1:0]     rows_full_q, rows_full_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  wr_en, row_done, rd_take, flush_go;
  logic [DATA_WIDTH-1:0] din;

  // Write path, row accounting and next state
  always_comb begin
    wr_en       = 1'b0;
    din         = '0;
    flush_go    = 1'b0;
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    rows_full_d = rows_full_q;

    case (state_q)
      RUN: begin
        wr_en = in_valid & in_ready_q;
        if (wr_en) din = in_data;
      end
      FLUSH: wr_en = 1'b1;  // pad with zeros until the row closes
      default: ;
    endcase

    row_done = wr_en && (word_cnt_q == WORD_LAST);
    rd_take  = out_valid_q & out_ready;

    if (wr_en) word_cnt_d = row_done ? '0 : ADDR_W'(word_cnt_q + 1'b1);

    if (row_done && !rd_take)      rows_full_d = FILL_W'(rows_full_q + 1'b1);
    else if (!row_done && rd_take) rows_full_d = FILL_W'(rows_full_q - 1'b1);

`ifdef LINE_BUF_CTRL_FLUSH_EN
    // Only a genuinely partial row that this cycle does not close is flushed
    flush_go = flush && (word_cnt_q != '0) && !row_done;
`endif

    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (flush_go) state_d = FLUSH;
      FLUSH:   if (row_done) state_d = RUN;
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == RUN) && (rows_full_d < DEPTH_C);
    out_valid_d = (rows_full_d != '0);
  end

  // State and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      rows_full_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      rows_full_q <= rows_full_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  line_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (row_done),
    .ptr_o (ram_wr_addr)
  );

  line_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (rd_take),
    .ptr_o (ram_rd_addr)
  );

  assign in_ready  = in_ready_q;
  assign ram_we    = wr_en;
  assign ram_din   = din;
  assign out_valid = out_valid_q;
  // A full 256-row buffer reads back as 0 on the 8-bit port
  assign rows_full = ADDR_W'(rows_full_q);

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Self-checking bench for line_buf_ctrl (DEPTH=4, LENGTH=3, DATA_WIDTH=16).
module tb_line_buf_ctrl;

  localparam int DEPTH  = 4;
  localparam int LENGTH = 3;
  localparam int DW     = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          in_ready, ram_we, out_valid;
  logic [DW-1:0] ram_din;
  logic [7:0]    ram_wr_addr, ram_rd_addr, rows_full;

  always #5 clk = ~clk;

  line_buf_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .LENGTH(LENGTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef LINE_BUF_CTRL_FLUSH_EN
    .flush       (flush),
`endif
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ram_we      (ram_we),
    .ram_din     (ram_din),
    .ram_wr_addr (ram_wr_addr),
    .ram_rd_addr (ram_rd_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rows_full   (rows_full)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: total rows written/read, words in the open row, mode
  int m_run, m_wc, m_wr, m_rd, m_fl;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
    int full, wc0, fl0;
    bit er, ewe, eov, done;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    #1;
    full = m_wr - m_rd;
    er   = (m_run != 0) && (m_fl == 0) && (full < DEPTH);
    ewe  = (m_fl != 0) || (v && er);
    eov  = (full != 0);
    chk("in_ready", int'(in_ready), int'(er));
    chk("ram_we", int'(ram_we), int'(ewe));
    chk("ram_din", int'(ram_din), (ewe && m_fl == 0) ? int'(d) : 0);
    chk("ram_wr_addr", int'(ram_wr_addr), m_wr % DEPTH);
    chk("ram_rd_addr", int'(ram_rd_addr), m_rd % DEPTH);
    chk("out_valid", int'(out_valid), int'(eov));
    chk("rows_full", int'(rows_full), full);
    wc0 = m_wc; fl0 = m_fl; done = 0;
    if (ewe) begin
      if (m_wc == LENGTH - 1) begin m_wc = 0; m_wr++; done = 1; end
      else m_wc++;
    end
    if (fl0 != 0) begin
      if (done) m_fl = 0;
    end else if (m_run != 0 && f && wc0 != 0 && !done) m_fl = 1;
    if (eov && r) m_rd++;
    m_run = 1;
  endtask

  // Assert reset just after a rising edge, confirm asynchronous clearing, release
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_run = 0; m_wc = 0; m_wr = 0; m_rd = 0; m_fl = 0;
    #1;
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst ram_we", int'(ram_we), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst rows_full", int'(rows_full), 0);
    chk("rst wr_addr", int'(ram_wr_addr), 0);
    chk("rst rd_addr", int'(ram_rd_addr), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          r;
    bit          ewe;
    bit          erdy;
    int          ewa;
    int          erf;
    bit          eov;
  } vec_t;

  vec_t tbl[5];

  initial begin
    // Streamed first row: IDLE cycle holds the word, then three writes at row 0
    tbl[0] = '{1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 16'd1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
    tbl[2] = '{1'b1, 16'd2, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
    tbl[3] = '{1'b1, 16'd3, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
    tbl[4] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b1};

    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
      chk($sformatf("tbl%0d we", i), int'(ram_we), int'(tbl[i].ewe));
      chk($sformatf("tbl%0d rdy", i), int'(in_ready), int'(tbl[i].erdy));
      chk($sformatf("tbl%0d wa", i), int'(ram_wr_addr), tbl[i].ewa);
      chk($sformatf("tbl%0d rf", i), int'(rows_full), tbl[i].erf);
      chk($sformatf("tbl%0d ov", i), int'(out_valid), int'(tbl[i].eov));
    end

    // Fill all four rows with no reader; the 13th word must be held
    do_reset();
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 16'd13, 1'b0, 1'b0);
    chk("full rows_full", int'(rows_full), 4);
    chk("full in_ready", int'(in_ready), 0);
    chk("full held we", int'(ram_we), 0);

    // One read from the full buffer, then the next row wraps to row 0
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    chk("read rd_addr before", int'(ram_rd_addr), 0);
    cyc(1'b1, 16'd14, 1'b0, 1'b0);
    chk("read rd_addr after", int'(ram_rd_addr), 1);
    chk("read rows_full", int'(rows_full), 3);
    chk("read in_ready", int'(in_ready), 1);
    chk("wrap wr_addr", int'(ram_wr_addr), 0);
    chk("wrap we", int'(ram_we), 1);
    cyc(1'b1, 16'd15, 1'b0, 1'b0);
    cyc(1'b1, 16'd16, 1'b0, 1'b0);

    // Drain to two rows, then complete a row in the same cycle as a read
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    cyc(1'b1, 16'd17, 1'b0, 1'b0);
    chk("simul pre rows_full", int'(rows_full), 2);
    cyc(1'b1, 16'd18, 1'b0, 1'b0);
    cyc(1'b1, 16'd19, 1'b1, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("simul rows_full", int'(rows_full), 2);

    // Reset with one complete row and two words of the next
    do_reset();
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(20 + i), 1'b0, 1'b0);
    chk("pre-rst rows_full", int'(rows_full), 1);
    in_valid = 1'b1;
    do_reset();
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    cyc(1'b1, 16'd30, 1'b0, 1'b0);
    chk("post-rst wr_addr", int'(ram_wr_addr), 0);
    cyc(1'b1, 16'd31, 1'b0, 1'b0);
    cyc(1'b1, 16'd32, 1'b0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("post-rst row done", int'(rows_full), 1);

`ifdef LINE_BUF_CTRL_FLUSH_EN
    // One word then flush: two zero pads, in_ready low for two cycles
    do_reset();
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    cyc(1'b1, 16'd40, 1'b0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    chk("flush req rdy", int'(in_ready), 1);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("flush1 rdy", int'(in_ready), 0);
    chk("flush1 we", int'(ram_we), 1);
    chk("flush1 din", int'(ram_din), 0);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("flush2 rdy", int'(in_ready), 0);
    chk("flush2 we", int'(ram_we), 1);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("flush done rdy", int'(in_ready), 1);
    chk("flush done rows", int'(rows_full), 1);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    chk("flush ignored rdy", int'(in_ready), 1);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    chk("flush ignored we", int'(ram_we), 0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit v, r, f;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0);
      f = 1'b0;
`ifdef LINE_BUF_CTRL_FLUSH_EN
      f = ($urandom_range(0, 9) == 0);
`endif
      cyc(v, 16'($urandom), r, f);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/line_buf_ctrl.md
LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of row buffers in the attached shift RAM (2..256).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-003 SHALL have parameter LENGTH, default 25, words per row (2..255).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream word valid.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  upstream word.
REQ-008 SHALL have port in_ready  output  1  controller accepts word this cycle.
REQ-009 SHALL have port ram_we  output  1  shift-RAM write/shift enable.
REQ-010 SHALL have port ram_din  output  DATA_WIDTH  word shifted into the RAM.
REQ-011 SHALL have port ram_wr_addr  output  8  row being filled.
REQ-012 SHALL have port ram_rd_addr  output  8  row presented to consumer.
REQ-013 SHALL have port out_valid  output  1  a complete row is on the RAM read port.
REQ-014 SHALL have port out_ready  input  1  consumer takes the row this cycle.
REQ-015 SHALL have port rows_full  output  8  count of complete, unread rows (0..DEPTH).

Function
REQ-016 SHALL use FSM states IDLE, RUN, FLUSH; IDLE->RUN on first cycle after reset release, RUN->FLUSH per REQ-029, FLUSH->RUN when the padded row completes.
REQ-017 SHALL drive in_ready = 1 only in RUN with rows_full < DEPTH.
REQ-018 SHALL drive ram_we = in_valid & in_ready in RUN, combinationally, with ram_din = in_data and ram_wr_addr = wr_row.
REQ-019 SHALL count accepted words in word_cnt (0..LENGTH-1); on the LENGTH-th word it clears word_cnt, advances wr_row modulo DEPTH, and increments rows_full.
REQ-020 SHALL assert out_valid registered, = (rows_full != 0), so a row is readable exactly one cycle after its last word write edge.
REQ-021 SHALL drive ram_rd_addr = rd_row; on out_valid & out_ready advance rd_row modulo DEPTH and decrement rows_full.
REQ-022 SHALL leave rows_full unchanged when a row completes and a row is read in the same cycle.
REQ-023 SHALL wrap wr_row and rd_row from DEPTH-1 to 0, and hold in_ready low while rows_full == DEPTH.
REQ-024 SHALL ignore out_ready while out_valid is 0 and ignore in_data while in_ready is 0.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear state to IDLE and clear word_cnt, wr_row, rd_row, rows_full, out_valid, in_ready, ram_we.
REQ-026 SHALL discard any partial row on reset mid-operation; the RAM contents are not required to be cleared by this block.

Configuration
REQ-027 SHALL compile flush support only when LINE_BUF_CTRL_FLUSH_EN is defined.
REQ-028 SHALL, with the macro, add port flush  input  1  request to close the partial row.
REQ-029 SHALL, with the macro, on flush in RUN with word_cnt != 0, enter FLUSH: in_ready = 0, ram_we = 1, ram_din = 0 each cycle until the row completes; flush with word_cnt == 0 is ignored.
REQ-030 SHALL, without the macro, have no flush port and never enter FLUSH.

Structure
REQ-031 SHALL place the state encoding (IDLE=0, RUN=1, FLUSH=2) and the address width constant (8) in shared package line_buf_pkg.
REQ-032 SHALL implement wr_row and rd_row with one sub-module line_buf_ptr, a modulo-DEPTH wrap counter with increment enable.

Verification (bench DEPTH=4, LENGTH=3, DATA_WIDTH=16)
REQ-033 SHALL cover: words 1,2,3 streamed -> three ram_we at wr_addr 0; out_valid = 1 next cycle, rows_full = 1.
REQ-034 SHALL cover: 12 words with out_ready = 0 -> rows_full = 4, in_ready = 0; word 13 is held, not written.
REQ-035 SHALL cover: full buffer, one read -> rd_addr 0->1, rows_full 3, in_ready = 1 next cycle; the next row is written at wr_addr 0 (wrap).
REQ-036 SHALL cover: row completion and read in the same cycle with rows_full = 2 -> rows_full stays 2.
REQ-037 SHALL cover, with LINE_BUF_CTRL_FLUSH_EN: 1 word then flush -> two ram_we with din 0, in_ready = 0 for 2 cycles, then RUN with rows_full = 1.
REQ-038 SHALL cover: rst_n low after 2 words of a row -> all outputs 0 asynchronously; after release, the next row starts at wr_addr 0 with word_cnt 0.
